// File: rtl/pwm_meter_if.sv
// PWM meter bus: the measured input and every measurement result.
// master = meter side, slave = consumer side.
interface pwm_meter_if #(
  parameter int W = 16
);
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;
  logic         level;
  logic [7:0]   duty;
  logic         duty_valid;

  modport master (
    input  pwm_in,
    output period, high_time, valid, timeout, level, duty, duty_valid
  );

  modport slave (
    output pwm_in,
    input  period, high_time, valid, timeout, level, duty, duty_valid
  );
endinterface

// File: rtl/pwm_meter.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
// Define PWM_METER_DUTY_EN to build in the sequential duty-cycle divider.
module pwm_meter #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  pwm_meter_if.master bus
);
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  typedef enum logic {ARM, MEASURE} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;
  logic                   level;
  logic                   rise;
  logic [W-1:0]           period_cnt, period_cnt_next;
  logic [W-1:0]           high_cnt, high_cnt_next;
  logic                   latch, set_timeout;
  logic [W-1:0]           period_q, high_q;
  logic                   latch_q, valid_q, timeout_q;

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      level_d <= level;
    end
  end

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_next      = state;
    period_cnt_next = period_cnt;
    high_cnt_next   = high_cnt;
    latch           = 1'b0;
    set_timeout     = 1'b0;
    case (state)
      ARM: begin
        period_cnt_next = '0;
        high_cnt_next   = '0;
        if (rise) begin
          state_next      = MEASURE;
          period_cnt_next = CNT_ONE;
          high_cnt_next   = CNT_ONE;
        end
      end
      MEASURE: begin
        // An edge arriving on the limit cycle wins over the timeout.
        if (rise) begin
          latch           = 1'b1;
          period_cnt_next = CNT_ONE;
          high_cnt_next   = CNT_ONE;
        end else if (period_cnt == CNT_MAX) begin
          set_timeout     = 1'b1;
          state_next      = ARM;
          period_cnt_next = '0;
          high_cnt_next   = '0;
        end else begin
          period_cnt_next = period_cnt + CNT_ONE;
          high_cnt_next   = high_cnt + {{(W-1){1'b0}}, level};
        end
      end
      default: state_next = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARM;
      period_cnt <= '0;
      high_cnt   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      latch_q    <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_next;
      period_cnt <= period_cnt_next;
      high_cnt   <= high_cnt_next;
      latch_q    <= latch;
      valid_q    <= latch_q;
      if (latch) begin
        period_q <= period_cnt;
        high_q   <= high_cnt;
      end
      if (set_timeout)
        timeout_q <= 1'b1;
      else if (latch)
        timeout_q <= 1'b0;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.level     = level;

`ifdef PWM_METER_DUTY_EN
  logic [W:0]   rem;
  logic [W-1:0] rem_trial;
  logic         q_bit;
  logic [8:0]   quo_next;
  logic [7:0]   quo;
  logic [3:0]   steps;
  logic [7:0]   duty_q;
  logic         duty_valid_q;

  always_comb begin
    q_bit     = rem >= {1'b0, period_q};
    rem_trial = q_bit ? W'(rem - {1'b0, period_q}) : rem[W-1:0];
    quo_next  = {quo, q_bit};
  end

  // Restoring division of high_time*256 by period, quotient MSB (weight 256) first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem          <= '0;
      quo          <= '0;
      steps        <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      duty_valid_q <= 1'b0;
      if (latch_q) begin
        rem   <= {1'b0, high_q};
        quo   <= '0;
        steps <= 4'd9;
      end else if (steps != 4'd0) begin
        rem   <= {rem_trial, 1'b0};
        quo   <= quo_next[7:0];
        steps <= steps - 4'd1;
        if (steps == 4'd1) begin
          duty_q       <= quo_next[8] ? 8'hFF : quo_next[7:0];
          duty_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
`else
  assign bus.duty       = 8'h00;
  assign bus.duty_valid = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_meter.sv
// Bench for pwm_meter: table vectors, corner sequences and random waveforms
// checked cycle by cycle against an edge-list reference model.
module tb_pwm_meter;
  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXC = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwm_meter_if #(.W(W)) bus ();
  pwm_meter #(.W(W), .SYNC_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  typedef struct {
    logic        valid, timeout, level, duty_valid;
    logic [31:0] period, high_time, duty;
  } obs_t;

  typedef struct { int p, h, reps, exp_period, exp_high, exp_duty; } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   wave_q[$];
  obs_t obs_q[$];
  obs_t exp_q[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int dsel(input int d);
`ifdef PWM_METER_DUTY_EN
    return d;
`else
    return 0;
`endif
  endfunction

  function automatic void add_periods(input int p, input int h, input int reps);
    repeat (reps) begin
      repeat (h) wave_q.push_back(1'b1);
      repeat (p - h) wave_q.push_back(1'b0);
    end
  endfunction

  function automatic void add_level(input bit v, input int len);
    repeat (len) wave_q.push_back(v);
  endfunction

  function automatic int count_valid(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi && i < obs_q.size(); i++)
      if (obs_q[i].valid === 1'b1) c++;
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    bus.pwm_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive wave_q[i] before edge i, record outputs 1ns after edge i.
  task automatic run_wave();
    obs_q.delete();
    foreach (wave_q[i]) begin
      obs_t o;
      @(negedge clk);
      bus.pwm_in = wave_q[i];
      @(posedge clk);
      #1;
      o.valid      = bus.valid;
      o.timeout    = bus.timeout;
      o.level      = bus.level;
      o.duty_valid = bus.duty_valid;
      o.period     = 32'(bus.period);
      o.high_time  = 32'(bus.high_time);
      o.duty       = 32'(bus.duty);
      obs_q.push_back(o);
    end
  endtask

  // Reference: a rise sampled at r is seen by the meter at edge r+S; results
  // change there, valid follows one edge later, duty nine edges after valid.
  task automatic build_model();
    int n = wave_q.size();
    int rises[$];
    int ve[$], vp[$], vh[$];
    int lat_p[], lat_h[], dv_d[];
    bit to_set[], to_clr[], vld[];
    bit armed = 1'b0;
    int last = 0;
    int p = 0, h = 0, duty = 0;
    bit to = 1'b0;
    lat_p = new[n]; lat_h = new[n]; dv_d = new[n];
    to_set = new[n]; to_clr = new[n]; vld = new[n];
    foreach (lat_p[i]) begin lat_p[i] = -1; dv_d[i] = -1; end
    for (int r = 0; r < n; r++)
      if (wave_q[r] && (r == 0 || !wave_q[r-1])) rises.push_back(r);
    foreach (rises[k]) begin
      int r, ones, le;
      r = rises[k];
      if (!armed) begin
        armed = 1'b1;
        last  = r;
      end else if (r - last > MAXC) begin
        if (last + S + MAXC < n) to_set[last + S + MAXC] = 1'b1;
        last = r;
      end else begin
        ones = 0;
        for (int i = last; i < r; i++) ones += int'(wave_q[i]);
        le = r + S;
        if (le < n) begin lat_p[le] = r - last; lat_h[le] = ones; to_clr[le] = 1'b1; end
        if (le + 1 < n) begin
          vld[le+1] = 1'b1;
          ve.push_back(le + 1); vp.push_back(r - last); vh.push_back(ones);
        end
        last = r;
      end
    end
    if (armed && last + S + MAXC < n) to_set[last + S + MAXC] = 1'b1;
`ifdef PWM_METER_DUTY_EN
    foreach (ve[k]) begin
      int q;
      if (k + 1 < ve.size() && ve[k+1] <= ve[k] + 9) continue;
      q = vh[k] * 256 / vp[k];
      if (ve[k] + 9 < n) dv_d[ve[k] + 9] = (q > 255) ? 255 : q;
    end
`endif
    exp_q.delete();
    for (int e = 0; e < n; e++) begin
      obs_t x;
      if (lat_p[e] >= 0) begin p = lat_p[e]; h = lat_h[e]; end
      if (to_set[e]) to = 1'b1;
      if (to_clr[e]) to = 1'b0;
      if (dv_d[e] >= 0) duty = dv_d[e];
      x.valid      = vld[e];
      x.timeout    = to;
      x.level      = (e - S + 1 >= 0) ? wave_q[e - S + 1] : 1'b0;
      x.duty_valid = (dv_d[e] >= 0);
      x.period     = p;
      x.high_time  = h;
      x.duty       = duty;
      exp_q.push_back(x);
    end
  endtask

  task automatic compare_all(input string tag);
    build_model();
    foreach (exp_q[i]) begin
      check($sformatf("%s[%0d].valid", tag, i),      obs_q[i].valid,      exp_q[i].valid);
      check($sformatf("%s[%0d].timeout", tag, i),    obs_q[i].timeout,    exp_q[i].timeout);
      check($sformatf("%s[%0d].level", tag, i),      obs_q[i].level,      exp_q[i].level);
      check($sformatf("%s[%0d].period", tag, i),     obs_q[i].period,     exp_q[i].period);
      check($sformatf("%s[%0d].high_time", tag, i),  obs_q[i].high_time,  exp_q[i].high_time);
      check($sformatf("%s[%0d].duty", tag, i),       obs_q[i].duty,       exp_q[i].duty);
      check($sformatf("%s[%0d].duty_valid", tag, i), obs_q[i].duty_valid, exp_q[i].duty_valid);
    end
  endtask

  task automatic random_wave(input int min_len);
    wave_q.delete();
    while (wave_q.size() < min_len) begin
      int kind, p, h;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        add_level(1'($urandom_range(0, 1)), int'($urandom_range(200, 320)));
      end else begin
        p = (kind == 1) ? int'($urandom_range(248, 260)) : int'($urandom_range(2, 60));
        h = int'($urandom_range(1, p - 1));
        add_periods(p, h, int'($urandom_range(1, 5)));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".period"},     32'(bus.period),    0);
    check({tag, ".high_time"},  32'(bus.high_time), 0);
    check({tag, ".valid"},      bus.valid,          0);
    check({tag, ".timeout"},    bus.timeout,        0);
    check({tag, ".level"},      bus.level,          0);
    check({tag, ".duty"},       32'(bus.duty),      0);
    check({tag, ".duty_valid"}, bus.duty_valid,     0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {p, h, reps, period, high_time, duty with divider}
    vecs[0] = '{100, 25, 3, 100, 25,  64};
    vecs[1] = '{ 50, 49, 3,  50, 49, 250};
    vecs[2] = '{  2,  1, 20,  2,  1, 128};
    vecs[3] = '{ 37,  1, 3,  37,  1,   6};
    vecs[4] = '{255, 200, 2, 255, 200, 200};
    vecs[5] = '{  3,  2, 6,   3,  2, 170};
    vecs[6] = '{ 10,  9, 4,  10,  9, 230};

    bus.pwm_in = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("reset");
    do_reset();

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      do_reset();
      wave_q.delete();
      add_periods(vecs[k].p, vecs[k].h, vecs[k].reps);
      add_level(1'b1, 1);
      add_level(1'b0, 20);
      run_wave();
      compare_all(tag);
      check({tag, ".n_valid"},   count_valid(0, obs_q.size() - 1), vecs[k].reps);
      check({tag, ".period"},    obs_q[$].period,    vecs[k].exp_period);
      check({tag, ".high_time"}, obs_q[$].high_time, vecs[k].exp_high);
      check({tag, ".duty"},      obs_q[$].duty,      dsel(vecs[k].exp_duty));
    end

    // Held high after three periods: timeout 255 cycles after the last edge.
    do_reset();
    wave_q.delete();
    add_periods(20, 5, 3);
    add_level(1'b1, 300);
    run_wave();
    compare_all("hi");
    check("hi.to_before",   obs_q[316].timeout,   0);
    check("hi.to_at_limit", obs_q[317].timeout,   1);
    check("hi.level",       obs_q[317].level,     1);
    check("hi.period",      obs_q[317].period,    20);
    check("hi.high_time",   obs_q[317].high_time, 5);
    check("hi.no_valid",    count_valid(64, obs_q.size() - 1), 0);

    // 49/50 duty, then constant low until timeout.
    do_reset();
    wave_q.delete();
    add_periods(50, 49, 3);
    add_level(1'b1, 1);
    add_level(1'b0, 300);
    run_wave();
    compare_all("lo");
    check("lo.to_before",   obs_q[406].timeout, 0);
    check("lo.to_at_limit", obs_q[407].timeout, 1);
    check("lo.level",       obs_q[407].level,   0);
    check("lo.duty",        obs_q[407].duty,    dsel(250));

    // Edge on the limit cycle is measured; one cycle later it times out.
    do_reset();
    wave_q.delete();
    add_level(1'b1, 10); add_level(1'b0, 245);
    add_level(1'b1, 10); add_level(1'b0, 246);
    add_level(1'b1, 10); add_level(1'b0, 300);
    run_wave();
    compare_all("lim");
    check("lim.to_edge_cycle", obs_q[257].timeout,   0);
    check("lim.valid",         obs_q[258].valid,     1);
    check("lim.period",        obs_q[258].period,    255);
    check("lim.high_time",     obs_q[258].high_time, 10);
    check("lim.to_after",      obs_q[258].timeout,   0);
    check("lim.to_gap256",     obs_q[512].timeout,   1);
    check("lim.no_valid",      count_valid(259, obs_q.size() - 1), 0);

    // Asynchronous reset between edges mid-measurement.
    do_reset();
    wave_q.delete();
    add_periods(30, 10, 3);
    add_level(1'b1, 5);
    run_wave();
    check("ar.pre_period", 32'(bus.period), 30);
    check("ar.pre_level",  bus.level,       1);
    #2;
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    #1 check_zero("ar.now");
    @(negedge clk);
    rst = 1'b0;
    wave_q.delete();
    add_level(1'b1, 7);
    add_level(1'b0, 13);
    add_periods(20, 7, 2);
    add_level(1'b0, 15);
    run_wave();
    compare_all("ar");
    check("ar.no_early_valid", count_valid(0, 22), 0);
    check("ar.first_valid",    obs_q[23].valid,  1);
    check("ar.first_period",   obs_q[23].period, 20);

    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      random_wave(1500);
      run_wave();
      compare_all($sformatf("rnd%0d", ph));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
